// File: rtl/rom_loader_pkg.sv
// Shared definitions for the instruction-ROM loader: state encoding, byte-index width
// and the ROM address width. ROM_LOADER_CHECKSUM_EN adds the CHECK state.
package rom_loader_pkg;

    localparam int ROM_ADDRESS_BITWIDTH = 14;
    localparam int BYTE_IDX_W           = 2;

    typedef enum logic [2:0] {
        ST_HEADER = 3'd0,
        ST_LOAD   = 3'd1,
`ifdef ROM_LOADER_CHECKSUM_EN
        ST_CHECK  = 3'd2,
`endif
        ST_DONE   = 3'd3,
        ST_ERROR  = 3'd4
    } state_t;

    // States in which the loader is willing to take bytes from the stream.
    function automatic logic state_accepts_bytes(input state_t s);
        logic w_ok;
        w_ok = (s == ST_HEADER) || (s == ST_LOAD);
`ifdef ROM_LOADER_CHECKSUM_EN
        w_ok = w_ok || (s == ST_CHECK);
`endif
        return w_ok;
    endfunction

endpackage

// File: rtl/rom_loader_if.sv
// Byte-stream input (valid/ready) and ROM write port of the loader.
// Transfer happens on a rising clock edge where in_valid and in_ready are both 1;
// in_ready never depends on in_valid, and rom_wren is a single-cycle write strobe.
interface rom_loader_if
    import rom_loader_pkg::*;
#(
    parameter int ADDRESS_WIDTH = ROM_ADDRESS_BITWIDTH
);
    logic                     in_valid;
    logic [7:0]               in_data;
    logic                     in_ready;
    logic                     rom_wren;
    logic [ADDRESS_WIDTH-1:0] rom_address;
    logic [31:0]              rom_write_data;

    modport master (
        output in_valid, in_data,
        input  in_ready, rom_wren, rom_address, rom_write_data
    );

    modport slave (
        input  in_valid, in_data,
        output in_ready, rom_wren, rom_address, rom_write_data
    );
endinterface

// File: rtl/rom_loader_byte_to_word_assembler.sv
// Collects four accepted bytes into a little-endian word. The word and its one-cycle
// valid are presented combinationally with the 4th byte so the loader can register the write.
module rom_loader_byte_to_word_assembler
    import rom_loader_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        i_clear,
    input  logic        i_valid,
    input  logic [7:0]  i_data,
    output logic [31:0] o_word,
    output logic        o_word_valid
);

    logic [BYTE_IDX_W-1:0] r_idx;
    logic [23:0]           r_low;

    always_ff @(posedge clk) begin
        if (reset || i_clear) begin
            r_idx <= '0;
            r_low <= '0;
        end else if (i_valid) begin
            r_idx <= r_idx + BYTE_IDX_W'(1);
            case (r_idx)
                2'd0:    r_low[7:0]   <= i_data;
                2'd1:    r_low[15:8]  <= i_data;
                2'd2:    r_low[23:16] <= i_data;
                default: ;
            endcase
        end
    end

    // The top byte is never stored: it is taken straight from the input.
    assign o_word       = {i_data, r_low};
    assign o_word_valid = i_valid && (r_idx == 2'd3);

endmodule

// File: rtl/rom_loader.sv
// Fills the instruction ROM from a byte stream (header word count N, then N words)
// and holds the CPU in reset until loading completes. Checksum: ROM_LOADER_CHECKSUM_EN.
module rom_loader
    import rom_loader_pkg::*;
#(
    parameter int ADDRESS_WIDTH = ROM_ADDRESS_BITWIDTH,
    parameter int COUNT_WIDTH   = 32
)
(
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   restart,
    rom_loader_if.slave            bus,
    output logic                   cpu_reset_n,
    output logic                   done,
    output logic                   error,
    output logic [COUNT_WIDTH-1:0] words_loaded,
    output state_t                 o_dbg_state
);

    localparam logic [COUNT_WIDTH-1:0] CAPACITY = COUNT_WIDTH'(1) << (ADDRESS_WIDTH - 2);

    state_t                   r_state, w_state_next;
    logic                     r_in_ready, r_done, r_error, r_cpu_reset_n;
    logic                     r_rom_wren, w_rom_wren_next;
    logic [ADDRESS_WIDTH-1:0] r_rom_address, w_rom_address_next;
    logic [31:0]              r_rom_write_data, w_rom_write_data_next;
    logic [COUNT_WIDTH-1:0]   r_words, w_words_next, w_words_inc;
    logic [COUNT_WIDTH-1:0]   r_count_n, w_count_n_next, w_header_n;
    logic                     w_accept, w_asm_valid, w_restart;
    logic [31:0]              w_word;
    logic                     w_word_valid;
`ifdef ROM_LOADER_CHECKSUM_EN
    logic [7:0]               r_sum, w_sum_next;
`endif

    assign w_accept    = bus.in_valid && r_in_ready;
    assign w_asm_valid = w_accept && ((r_state == ST_HEADER) || (r_state == ST_LOAD));
    assign w_restart   = restart && ((r_state == ST_DONE) || (r_state == ST_ERROR));
    assign w_words_inc = r_words + COUNT_WIDTH'(1);
    assign w_header_n  = COUNT_WIDTH'(w_word);

    rom_loader_byte_to_word_assembler u_asm (
        .clk          (clk),
        .reset        (reset),
        .i_clear      (w_restart),
        .i_valid      (w_asm_valid),
        .i_data       (bus.in_data),
        .o_word       (w_word),
        .o_word_valid (w_word_valid)
    );

    always_comb begin
        w_state_next          = r_state;
        w_count_n_next        = r_count_n;
        w_words_next          = r_words;
        w_rom_wren_next       = 1'b0;
        w_rom_address_next    = r_rom_address;
        w_rom_write_data_next = r_rom_write_data;
`ifdef ROM_LOADER_CHECKSUM_EN
        w_sum_next            = r_sum;
`endif
        case (r_state)
            ST_HEADER: begin
`ifdef ROM_LOADER_CHECKSUM_EN
                w_sum_next = '0;
`endif
                if (w_word_valid) begin
                    w_count_n_next = w_header_n;
                    if (w_header_n > CAPACITY) begin
                        w_state_next = ST_ERROR;
                    end else if (w_header_n == '0) begin
`ifdef ROM_LOADER_CHECKSUM_EN
                        w_state_next = ST_CHECK;
`else
                        w_state_next = ST_DONE;
`endif
                    end else begin
                        w_state_next = ST_LOAD;
                    end
                end
            end
            ST_LOAD: begin
`ifdef ROM_LOADER_CHECKSUM_EN
                if (w_accept) w_sum_next = r_sum + bus.in_data;
`endif
                // The write is registered, so it lands on the cycle after the 4th byte.
                if (w_word_valid) begin
                    w_rom_wren_next       = 1'b1;
                    w_rom_address_next    = {r_words[ADDRESS_WIDTH-3:0], 2'b00};
                    w_rom_write_data_next = w_word;
                    w_words_next          = w_words_inc;
                    if (w_words_inc == r_count_n) begin
`ifdef ROM_LOADER_CHECKSUM_EN
                        w_state_next = ST_CHECK;
`else
                        w_state_next = ST_DONE;
`endif
                    end
                end
            end
`ifdef ROM_LOADER_CHECKSUM_EN
            ST_CHECK: begin
                if (w_accept) w_state_next = (bus.in_data == r_sum) ? ST_DONE : ST_ERROR;
            end
`endif
            ST_DONE, ST_ERROR: begin
                if (restart) begin
                    w_state_next   = ST_HEADER;
                    w_words_next   = '0;
                    w_count_n_next = '0;
                end
            end
            default: w_state_next = ST_HEADER;
        endcase
    end

    // Status outputs are registered from the next state, so they change with the state.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state          <= ST_HEADER;
            r_in_ready       <= 1'b0;
            r_done           <= 1'b0;
            r_error          <= 1'b0;
            r_cpu_reset_n    <= 1'b0;
            r_rom_wren       <= 1'b0;
            r_rom_address    <= '0;
            r_rom_write_data <= '0;
            r_words          <= '0;
            r_count_n        <= '0;
`ifdef ROM_LOADER_CHECKSUM_EN
            r_sum            <= '0;
`endif
        end else begin
            r_state          <= w_state_next;
            r_in_ready       <= state_accepts_bytes(w_state_next);
            r_done           <= (w_state_next == ST_DONE);
            r_error          <= (w_state_next == ST_ERROR);
            r_cpu_reset_n    <= (w_state_next == ST_DONE);
            r_rom_wren       <= w_rom_wren_next;
            r_rom_address    <= w_rom_address_next;
            r_rom_write_data <= w_rom_write_data_next;
            r_words          <= w_words_next;
            r_count_n        <= w_count_n_next;
`ifdef ROM_LOADER_CHECKSUM_EN
            r_sum            <= w_sum_next;
`endif
        end
    end

    assign bus.in_ready       = r_in_ready;
    assign bus.rom_wren       = r_rom_wren;
    assign bus.rom_address    = r_rom_address;
    assign bus.rom_write_data = r_rom_write_data;
    assign cpu_reset_n        = r_cpu_reset_n;
    assign done               = r_done;
    assign error              = r_error;
    assign words_loaded       = r_words;
    assign o_dbg_state        = r_state;

endmodule

// File: tb/tb_rom_loader.sv
// Bench for rom_loader: directed byte streams, a stream-level model of the ROM writes,
// and a per-cycle compare inside tick(). Honours ROM_LOADER_CHECKSUM_EN.
`timescale 1ns/1ps
module tb_rom_loader;
    import rom_loader_pkg::*;

    localparam int AW  = 14;
    localparam int CW  = 32;
    localparam int CAP = 1 << (AW - 2);
    localparam int EW  = AW + 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          restart;
    logic          cpu_reset_n;
    logic          done;
    logic          error;
    logic [CW-1:0] words_loaded;
    state_t        dbg_state;

    rom_loader_if #(.ADDRESS_WIDTH(AW)) bus ();

    rom_loader #(.ADDRESS_WIDTH(AW), .COUNT_WIDTH(CW)) dut (
        .clk          (clk),
        .reset        (reset),
        .restart      (restart),
        .bus          (bus),
        .cpu_reset_n  (cpu_reset_n),
        .done         (done),
        .error        (error),
        .words_loaded (words_loaded),
        .o_dbg_state  (dbg_state)
    );

    always #5 clk = ~clk;

    int            checks = 0;
    int            errors = 0;
    bit            mon_en = 1'b0;
    logic [EW-1:0] exp_q[$];
    logic [EW-1:0] wr_log[$];
    logic [7:0]    stim_q[$];
    logic          exp_done, exp_error;
    logic [CW-1:0] exp_words;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic monitor();
        logic [EW-1:0] got, want;
        if (bus.rom_wren) begin
            got = {bus.rom_address, bus.rom_write_data};
            wr_log.push_back(got);
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL wr_unexpected actual=%0h required=no_write", got);
            end else begin
                want = exp_q.pop_front();
                if (got !== want) begin
                    errors++;
                    $display("FAIL wr_word actual=%0h required=%0h", got, want);
                end
            end
        end
        if (dbg_state == ST_LOAD) check("load_in_ready", bus.in_ready, 1);
        if (dbg_state == ST_HEADER || dbg_state == ST_LOAD) check("busy_cpu_held", cpu_reset_n, 0);
        if (error) check("err_cpu_held", cpu_reset_n, 0);
        if (error) check("err_in_ready", bus.in_ready, 0);
        if (done) check("done_cpu_run", cpu_reset_n, 1);
    endtask

    // All time advances through here; outputs are sampled 1 ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
        if (mon_en) monitor();
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int waited;
        bus.in_valid = 1'b0;
        repeat (gap) tick();
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        waited = 0;
        while (!bus.in_ready && waited < 20) begin
            tick();
            waited++;
        end
        check("send_ready", bus.in_ready, 1);
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic push_word(input logic [31:0] w);
        for (int k = 0; k < 4; k++) stim_q.push_back(w[8*k +: 8]);
    endtask

    task automatic push_checksum();
`ifdef ROM_LOADER_CHECKSUM_EN
        logic [7:0] s;
        s = 8'h00;
        for (int i = 4; i < stim_q.size(); i++) s = s + stim_q[i];
        stim_q.push_back(s);
`endif
    endtask

    // Stream-level model: header is N, words follow little-endian, word i goes to byte address 4*i.
    task automatic model_load();
        logic [31:0] n, w;
        logic [7:0]  s;
        n = {stim_q[3], stim_q[2], stim_q[1], stim_q[0]};
        exp_done  = 1'b0;
        exp_error = 1'b0;
        exp_words = '0;
        if (n > CAP) begin
            exp_error = 1'b1;
        end else begin
            for (int i = 0; i < int'(n); i++) begin
                w = {stim_q[4 + 4*i + 3], stim_q[4 + 4*i + 2], stim_q[4 + 4*i + 1], stim_q[4 + 4*i]};
                exp_q.push_back({AW'(i * 4), w});
            end
            exp_words = n;
            exp_done  = 1'b1;
            s = 8'h00;
            for (int i = 4; i < 4 + 4 * int'(n); i++) s = s + stim_q[i];
`ifdef ROM_LOADER_CHECKSUM_EN
            if (stim_q[4 + 4 * int'(n)] != s) begin
                exp_done  = 1'b0;
                exp_error = 1'b1;
            end
`endif
        end
    endtask

    task automatic send_stream(input int first, input int last, input int gap_max);
        for (int i = first; i <= last; i++) send_byte(stim_q[i], $urandom_range(0, gap_max));
    endtask

    task automatic final_check(input string name);
        tick();
        tick();
        check({name, "_done"}, done, exp_done);
        check({name, "_error"}, error, exp_error);
        check({name, "_cpu_reset_n"}, cpu_reset_n, exp_done);
        check({name, "_words"}, words_loaded, exp_words);
        check({name, "_in_ready"}, bus.in_ready, 0);
        check({name, "_pending_writes"}, exp_q.size(), 0);
    endtask

    task automatic run_load(input string name, input int gap_max);
        wr_log.delete();
        model_load();
        send_stream(0, stim_q.size() - 1, gap_max);
        final_check(name);
    endtask

    task automatic do_reset();
        mon_en       = 1'b0;
        reset        = 1'b1;
        restart      = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        tick();
        tick();
        check("rst_state", dbg_state, ST_HEADER);
        check("rst_wren", bus.rom_wren, 0);
        check("rst_addr", bus.rom_address, 0);
        check("rst_wdata", bus.rom_write_data, 0);
        check("rst_cpu_reset_n", cpu_reset_n, 0);
        check("rst_done", done, 0);
        check("rst_error", error, 0);
        check("rst_words", words_loaded, 0);
        check("rst_in_ready", bus.in_ready, 0);
        exp_q.delete();
        reset = 1'b0;
        tick();
        check("rst_in_ready_rise", bus.in_ready, 1);
        mon_en = 1'b1;
    endtask

    task automatic do_restart(input string name);
        restart = 1'b1;
        tick();
        restart = 1'b0;
        check({name, "_rs_state"}, dbg_state, ST_HEADER);
        check({name, "_rs_cpu_reset_n"}, cpu_reset_n, 0);
        check({name, "_rs_done"}, done, 0);
        check({name, "_rs_error"}, error, 0);
        check({name, "_rs_words"}, words_loaded, 0);
        check({name, "_rs_in_ready"}, bus.in_ready, 1);
    endtask

    initial begin
        do_reset();

        // Two words: 0x00000013 and 0xDEADBEEF.
        stim_q.delete();
        push_word(32'd2);
        push_word(32'h0000_0013);
        push_word(32'hDEAD_BEEF);
        push_checksum();
        wr_log.delete();
        model_load();
        send_stream(0, 11, 0);
`ifndef ROM_LOADER_CHECKSUM_EN
        check("t1_done_with_last_write", {bus.rom_wren, done}, 2'b11);
`else
        send_stream(12, 12, 0);
`endif
        final_check("t1");
        check("t1_wr_count", wr_log.size(), 2);
        check("t1_wr0", wr_log[0], {14'h0000, 32'h0000_0013});
        check("t1_wr1", wr_log[1], {14'h0004, 32'hDEAD_BEEF});
        check("t1_words_lit", words_loaded, 2);
        check("t1_done_lit", done, 1);
        do_restart("t1");

        // Empty program.
        stim_q.delete();
        push_word(32'd0);
        push_checksum();
        run_load("t2", 0);
        check("t2_no_writes", wr_log.size(), 0);
        check("t2_done_lit", done, 1);
        do_restart("t2");

        // One word over capacity.
        stim_q.delete();
        push_word(32'(CAP + 1));
        run_load("t3", 0);
        check("t3_no_writes", wr_log.size(), 0);
        check("t3_error_lit", error, 1);
        check("t3_in_ready_lit", bus.in_ready, 0);
        do_restart("t3");

        // N=3 without gaps, then with random 0..5 cycle gaps.
        stim_q.delete();
        push_word(32'd3);
        push_word(32'h1122_3344);
        push_word(32'hA5A5_5A5A);
        push_word(32'h00FF_00FF);
        push_checksum();
        run_load("t4a", 0);
        check("t4a_wr_count", wr_log.size(), 3);
        check("t4a_wr2", wr_log[2], {14'h0008, 32'h00FF_00FF});
        do_restart("t4a");
        run_load("t4b", 5);
        check("t4b_wr_count", wr_log.size(), 3);
        check("t4b_wr1", wr_log[1], {14'h0004, 32'hA5A5_5A5A});
        do_restart("t4b");

        // Reset after 2 of 4 words, then a fresh N=1 load.
        stim_q.delete();
        push_word(32'd4);
        push_word(32'h0101_0101);
        push_word(32'h0202_0202);
        push_word(32'h0303_0303);
        push_word(32'h0404_0404);
        push_checksum();
        wr_log.delete();
        model_load();
        send_stream(0, 11, 0);
        tick();
        check("t5_words_mid", words_loaded, 2);
        check("t5_writes_mid", wr_log.size(), 2);
        check("t5_pending_mid", exp_q.size(), 2);
        do_reset();
        stim_q.delete();
        push_word(32'd1);
        push_word(32'hCAFE_F00D);
        push_checksum();
        run_load("t5", 0);
        check("t5_wr_count", wr_log.size(), 1);
        check("t5_wr0", wr_log[0], {14'h0000, 32'hCAFE_F00D});
        check("t5_done_lit", done, 1);

`ifdef ROM_LOADER_CHECKSUM_EN
        // Checksum over 01 02 03 04 is 0x0A.
        do_restart("t5");
        stim_q.delete();
        push_word(32'd1);
        push_word(32'h0403_0201);
        stim_q.push_back(8'h0A);
        run_load("t6a", 0);
        check("t6a_done_lit", done, 1);
        do_restart("t6a");
        stim_q.delete();
        push_word(32'd1);
        push_word(32'h0403_0201);
        stim_q.push_back(8'h0B);
        run_load("t6b", 0);
        check("t6b_error_lit", error, 1);
        check("t6b_wr_count", wr_log.size(), 1);
        do_restart("t6b");
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
